// File: rtl/conv_acc_requant.sv
// Accumulate-and-requantise stage for the conv2 product stream.
// Sums one window of signed products into a wide saturating accumulator,
// adds the channel bias, rounds/shifts to activation scale, clamps, applies
// optional ReLU and hands one activation downstream over valid/ready.
module conv_acc_requant #(
    parameter int PROD_W = 22,
    parameter int ACC_W  = 32,
    parameter int OUT_W  = 14,
    parameter int SHIFT  = 8
) (
    input  logic                     ap_clk,
    input  logic                     ap_rst,
    input  logic                     prod_valid,
    output logic                     prod_ready,
    input  logic signed [PROD_W-1:0] prod_data,
    input  logic                     prod_last,
    input  logic signed [ACC_W-1:0]  bias,
    input  logic                     relu_en,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [OUT_W-1:0]  out_data,
    output logic                     out_ovf
);

    typedef enum logic [1:0] {ACC, BIAS, ROUND, EMIT} state_t;

    // Rounding constant and output clamp limits, held at ACC_W+1 bits so the
    // rounded value can be compared before it is narrowed.
    localparam logic signed [ACC_W:0] ROUND_HALF = (ACC_W+1)'(64'sd1 <<< (SHIFT - 1));
    localparam logic signed [ACC_W:0] OUT_MAX    = (ACC_W+1)'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [ACC_W:0] OUT_MIN    = (ACC_W+1)'(-(64'sd1 <<< (OUT_W - 1)));

    state_t                   state;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  bias_q;
    logic                     relu_en_q;
    logic                     first_q;
    logic                     ovf_q;

    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  add_b;
    logic        [ACC_W:0]    add_res;
    logic        [OUT_W:0]    rq_res;

    // Saturating add; MSB of the result flags that clamping happened.
    function automatic logic [ACC_W:0] sat_add(input logic signed [ACC_W-1:0] a,
                                               input logic signed [ACC_W-1:0] b);
        logic signed [ACC_W:0] s;
        s = $signed({a[ACC_W-1], a}) + $signed({b[ACC_W-1], b});
        if (s[ACC_W] != s[ACC_W-1])
            return {1'b1, s[ACC_W], {(ACC_W-1){~s[ACC_W]}}};
        return {1'b0, s[ACC_W-1:0]};
    endfunction

    // Round half toward +inf, arithmetic shift, clamp to the activation range,
    // then ReLU. MSB of the result flags the clamp (ReLU never sets it).
    function automatic logic [OUT_W:0] requant(input logic signed [ACC_W-1:0] a,
                                               input logic relu);
        logic signed [ACC_W:0]   r;
        logic signed [OUT_W-1:0] v;
        logic                    clamp;
        r     = ($signed({a[ACC_W-1], a}) + ROUND_HALF) >>> SHIFT;
        clamp = 1'b0;
        if (r > OUT_MAX) begin
            v     = OUT_MAX[OUT_W-1:0];
            clamp = 1'b1;
        end else if (r < OUT_MIN) begin
            v     = OUT_MIN[OUT_W-1:0];
            clamp = 1'b1;
        end else begin
            v = r[OUT_W-1:0];
        end
        if (relu && v[OUT_W-1])
            v = '0;
        return {clamp, v};
    endfunction

    // One shared saturating adder: products while accumulating, bias afterwards.
    always_comb begin
        prod_ext = {{(ACC_W-PROD_W){prod_data[PROD_W-1]}}, prod_data};
        add_b    = (state == BIAS) ? bias_q : prod_ext;
        add_res  = sat_add(acc, add_b);
        rq_res   = requant(acc, relu_en_q);
    end

    // Window FSM: accumulate, add bias, requantise, then hold the result until taken.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state      <= ACC;
            acc        <= '0;
            first_q    <= 1'b1;
            ovf_q      <= 1'b0;
            prod_ready <= 1'b1;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_ovf    <= 1'b0;
        end else begin
            case (state)
                ACC: begin
                    if (prod_valid && prod_ready) begin
                        first_q <= 1'b0;
                        if (first_q) begin
                            acc       <= prod_ext;
                            bias_q    <= bias;
                            relu_en_q <= relu_en;
                            ovf_q     <= 1'b0;
                        end else begin
                            acc   <= add_res[ACC_W-1:0];
                            ovf_q <= ovf_q | add_res[ACC_W];
                        end
                        if (prod_last) begin
                            prod_ready <= 1'b0;
                            state      <= BIAS;
                        end
                    end
                end
                BIAS: begin
                    acc   <= add_res[ACC_W-1:0];
                    ovf_q <= ovf_q | add_res[ACC_W];
                    state <= ROUND;
                end
                ROUND: begin
                    out_data  <= rq_res[OUT_W-1:0];
                    out_ovf   <= ovf_q | rq_res[OUT_W];
                    out_valid <= 1'b1;
                    state     <= EMIT;
                end
                EMIT: begin
                    if (out_ready) begin
                        out_valid  <= 1'b0;
                        prod_ready <= 1'b1;
                        first_q    <= 1'b1;
                        state      <= ACC;
                    end
                end
                default: state <= ACC;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_acc_requant.sv
// Self-checking bench for conv_acc_requant: directed windows from the test
// plan plus randomized windows, all checked against an arithmetic model.
module tb_conv_acc_requant;

    localparam int PROD_W = 22;
    localparam int ACC_W  = 32;
    localparam int OUT_W  = 14;
    localparam int SHIFT  = 8;

    localparam longint AMAX = (64'sd1 <<< (ACC_W - 1)) - 1;
    localparam longint AMIN = -(64'sd1 <<< (ACC_W - 1));
    localparam longint OMAX = (64'sd1 <<< (OUT_W - 1)) - 1;
    localparam longint OMIN = -(64'sd1 <<< (OUT_W - 1));
    localparam longint SCALE = 64'sd1 <<< SHIFT;

    logic                     ap_clk = 1'b0;
    logic                     ap_rst;
    logic                     prod_valid;
    logic                     prod_ready;
    logic signed [PROD_W-1:0] prod_data;
    logic                     prod_last;
    logic signed [ACC_W-1:0]  bias;
    logic                     relu_en;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [OUT_W-1:0]  out_data;
    logic                     out_ovf;

    int errors = 0;
    int checks = 0;

    conv_acc_requant #(
        .PROD_W(PROD_W), .ACC_W(ACC_W), .OUT_W(OUT_W), .SHIFT(SHIFT)
    ) dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst),
        .prod_valid(prod_valid), .prod_ready(prod_ready),
        .prod_data(prod_data), .prod_last(prod_last),
        .bias(bias), .relu_en(relu_en),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_ovf(out_ovf)
    );

    always #5 ap_clk = ~ap_clk;

    // Reference: saturating running sum, bias, floor((acc + SCALE/2) / SCALE), clamp, ReLU.
    function automatic void model(input longint p[$], input longint b, input bit r,
                                  output longint d, output bit o);
        longint a, q;
        o = 1'b0;
        a = p[0];
        for (int i = 1; i < p.size(); i++) begin
            a += p[i];
            if (a > AMAX) begin a = AMAX; o = 1'b1; end
            else if (a < AMIN) begin a = AMIN; o = 1'b1; end
        end
        a += b;
        if (a > AMAX) begin a = AMAX; o = 1'b1; end
        else if (a < AMIN) begin a = AMIN; o = 1'b1; end
        q = a + SCALE / 2;
        if (q >= 0) d = q / SCALE;
        else        d = -((-q + SCALE - 1) / SCALE);
        if (d > OMAX) begin d = OMAX; o = 1'b1; end
        else if (d < OMIN) begin d = OMIN; o = 1'b1; end
        if (r && d < 0) d = 0;
    endfunction

    // Drives one window, waits for the result, optionally stalls, then handshakes.
    task automatic do_window(input string name, input longint p[$], input longint b,
                             input bit r, input int stall, input bit gaps);
        longint ed;
        bit     eo;
        int     t, lat;
        model(p, b, r, ed, eo);
        for (int i = 0; i < p.size(); i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    prod_valid = 1'b0;
                    prod_data  = PROD_W'($urandom);
                    @(negedge ap_clk);
                end
            end
            prod_valid = 1'b1;
            prod_data  = PROD_W'(p[i]);
            prod_last  = (i == p.size() - 1);
            bias       = (i == 0) ? ACC_W'(b) : ACC_W'($urandom);
            relu_en    = (i == 0) ? r : 1'($urandom);
            t = 0;
            while (!prod_ready && t < 50) begin @(negedge ap_clk); t++; end
            checks++;
            if (t >= 50) begin
                errors++;
                $display("FAIL %s ready_timeout: prod_ready=%0b required 1", name, prod_ready);
            end
            @(negedge ap_clk);
        end
        // Junk beats while the stage is busy must be ignored.
        prod_valid = (stall > 0);
        prod_last  = 1'b1;
        prod_data  = PROD_W'($urandom);
        lat = 1;
        while (!out_valid && lat < 20) begin @(negedge ap_clk); lat++; end
        checks++;
        if (lat != 3) begin
            errors++;
            $display("FAIL %s latency: got %0d cycles required 3", name, lat);
        end
        checks++;
        if (longint'(out_data) !== ed) begin
            errors++;
            $display("FAIL %s data: got %0d required %0d", name, out_data, ed);
        end
        checks++;
        if (out_ovf !== eo) begin
            errors++;
            $display("FAIL %s ovf: got %0b required %0b", name, out_ovf, eo);
        end
        for (int s = 0; s < stall; s++) begin
            @(negedge ap_clk);
            checks++;
            if (out_valid !== 1'b1 || longint'(out_data) !== ed || out_ovf !== eo || prod_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s stall%0d: valid=%0b data=%0d ovf=%0b ready=%0b required 1/%0d/%0b/0",
                         name, s, out_valid, out_data, out_ovf, prod_ready, ed, eo);
            end
        end
        prod_valid = 1'b0;
        prod_last  = 1'b0;
        out_ready  = 1'b1;
        @(negedge ap_clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || prod_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s after_hs: valid=%0b ready=%0b required 0/1", name, out_valid, prod_ready);
        end
    endtask

    task automatic check_reset_state(input string name);
        checks++;
        if (prod_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== '0 || out_ovf !== 1'b0) begin
            errors++;
            $display("FAIL %s: ready=%0b valid=%0b data=%0d ovf=%0b required 1/0/0/0",
                     name, prod_ready, out_valid, out_data, out_ovf);
        end
    endtask

    task automatic test_reset();
        ap_rst = 1'b1; prod_valid = 1'b0; prod_data = '0; prod_last = 1'b0;
        bias = '0; relu_en = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge ap_clk);
        ap_rst = 1'b0;
        @(negedge ap_clk);
        check_reset_state("reset_state");
    endtask

    task automatic test_basic();
        longint q[$];
        q = '{256, 256, 256};
        do_window("basic", q, 0, 1'b0, 0, 1'b0);
    endtask

    task automatic test_rounding();
        longint q[$];
        q = '{128};  do_window("round_128", q, 0, 1'b0, 0, 1'b0);
        q = '{-128}; do_window("round_m128", q, 0, 1'b0, 0, 1'b0);
        q = '{-129}; do_window("round_m129", q, 0, 1'b0, 0, 1'b0);
        q = '{383};  do_window("round_383", q, 0, 1'b0, 0, 1'b0);
        q = '{640};  do_window("round_bias", q, -256, 1'b0, 0, 1'b0);
    endtask

    task automatic test_saturation();
        longint q[$];
        q = '{2097151, 2097151};   do_window("sat_pos", q, 0, 1'b0, 0, 1'b0);
        q = '{-2097152, -2097152}; do_window("sat_neg", q, 0, 1'b0, 0, 1'b0);
        q = '{2097151, 1000};      do_window("acc_sat_pos", q, AMAX - 5000, 1'b0, 0, 1'b0);
        q = '{-2097152};           do_window("acc_sat_neg", q, AMIN + 10, 1'b1, 0, 1'b0);
    endtask

    task automatic test_relu();
        longint q[$];
        q = '{-2560};
        do_window("relu_on", q, 0, 1'b1, 0, 1'b0);
        do_window("relu_off", q, 0, 1'b0, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        longint q[$];
        q = '{1000, 2000, -700};
        do_window("bp_stall", q, 77, 1'b0, 5, 1'b0);
        q = '{300};
        do_window("bp_next", q, 0, 1'b0, 0, 1'b0);
    endtask

    task automatic test_reset_mid_window();
        longint q[$];
        for (int i = 0; i < 2; i++) begin
            prod_valid = 1'b1; prod_data = PROD_W'(1000); prod_last = 1'b0;
            bias = ACC_W'(5000); relu_en = 1'b0;
            @(negedge ap_clk);
        end
        prod_valid = 1'b0;
        ap_rst     = 1'b1;
        @(negedge ap_clk);
        ap_rst = 1'b0;
        check_reset_state("mid_reset_state");
        q = '{512};
        do_window("mid_reset_win", q, 0, 1'b0, 0, 1'b0);
    endtask

    task automatic test_random();
        longint q[$];
        longint b;
        logic signed [PROD_W-1:0] v;
        for (int w = 0; w < 40; w++) begin
            q.delete();
            for (int i = 0; i < int'($urandom_range(1, 6)); i++) begin
                if ($urandom_range(0, 1) == 0) q.push_back(longint'($urandom_range(0, 6000)) - 3000);
                else begin
                    v = PROD_W'($urandom);
                    q.push_back(longint'(v));
                end
            end
            case ($urandom_range(0, 2))
                0:       b = 0;
                1:       b = longint'($urandom_range(0, 40000)) - 20000;
                default: b = longint'($signed(32'($urandom)));
            endcase
            do_window($sformatf("rand%0d", w), q, b, 1'($urandom), int'($urandom_range(0, 3)), 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rounding();
        test_saturation();
        test_relu();
        test_backpressure();
        test_reset_mid_window();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
